// File: rtl/switch_time_sequencer.sv
// Schedule engine: toggles ctl at each time in a strictly increasing table.
// Build option SWITCH_SEQ_REPEAT_EN: replay the table until abort.
module switch_time_sequencer #(
   parameter int DEPTH = 8,
   parameter int TW = 32,
   parameter bit INIT = 1'b0,
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [TW-1:0] wr_time,
   input  logic          clear,
   input  logic          start,
   input  logic          abort,
   output logic          busy,
   output logic          done,
   output logic          ctl,
   output logic          evt_pulse,
   output logic [IW-1:0] evt_idx,
   output logic          err
);

   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t        state;
   logic [TW-1:0] tbl [DEPTH];
   logic [CW-1:0] count;
   logic [IW-1:0] idx;
   logic [IW-1:0] last_idx;
   logic [TW-1:0] timer;
   logic          ordered;
   logic          wr_try;
   logic          wr_fire;
   logic          wr_bad;
   logic          match;
   logic          last_hit;
   logic          go_empty;

   assign wr_ready = (state == S_IDLE)
                   && (count < CW'(DEPTH));
   assign last_idx = IW'(count - CW'(1));
   assign ordered  = (count == '0)
                   || (wr_time > tbl[last_idx]);
   assign wr_try   = wr_valid && wr_ready && !clear;
   assign wr_fire  = wr_try && ordered;
   assign wr_bad   = wr_try && !ordered;
   assign match    = (timer == tbl[idx]);
   assign last_hit = (CW'(idx) == count - CW'(1));
   // A run needs at least one entry, counting a same-cycle write.
   assign go_empty = clear
                   || ((count == '0) && !wr_fire);

   // Table storage carries no reset; count defines valid entries.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         tbl[IW'(count)] <= wr_time;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         count     <= '0;
         idx       <= '0;
         timer     <= '0;
         ctl       <= INIT;
         busy      <= 1'b0;
         done      <= 1'b0;
         evt_pulse <= 1'b0;
         evt_idx   <= '0;
         err       <= 1'b0;
      end else begin
         done      <= 1'b0;
         evt_pulse <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (clear) begin
                  count <= '0;
                  err   <= 1'b0;
               end else if (wr_fire) begin
                  count <= count + CW'(1);
               end else if (wr_bad) begin
                  err <= 1'b1;
               end
               if (start) begin
                  ctl   <= INIT;
                  idx   <= '0;
                  timer <= '0;
                  if (go_empty) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= S_RUN;
                     busy  <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (abort) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                  ctl   <= INIT;
                  idx   <= '0;
               end else begin
                  timer <= timer + TW'(1);
                  if (match) begin
                     ctl       <= ~ctl;
                     evt_pulse <= 1'b1;
                     evt_idx   <= idx;
                     idx       <= idx + IW'(1);
                     if (last_hit) begin
                        done <= 1'b1;
                        idx  <= '0;
`ifdef SWITCH_SEQ_REPEAT_EN
                        timer <= '0;
`else
                        state <= S_DONE;
                        busy  <= 1'b0;
`endif
                     end
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_switch_time_sequencer.sv
// Scoreboard bench for switch_time_sequencer (DEPTH=8, INIT=0).
// Repeat-mode checks are built when SWITCH_SEQ_REPEAT_EN is defined.
module tb_switch_time_sequencer;

   localparam int DEPTH = 8;
   localparam int TW = 32;
`ifdef SWITCH_SEQ_REPEAT_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif

   logic          clk;
   logic          rst_n;
   logic          wr_valid;
   logic          wr_ready;
   logic [TW-1:0] wr_time;
   logic          clear;
   logic          start;
   logic          abort;
   logic          busy;
   logic          done;
   logic          ctl;
   logic          evt_pulse;
   logic [2:0]    evt_idx;
   logic          err;

   switch_time_sequencer #(
      .DEPTH(DEPTH),
      .TW(TW),
      .INIT(1'b0)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .wr_valid(wr_valid),
      .wr_ready(wr_ready),
      .wr_time(wr_time),
      .clear(clear),
      .start(start),
      .abort(abort),
      .busy(busy),
      .done(done),
      .ctl(ctl),
      .evt_pulse(evt_pulse),
      .evt_idx(evt_idx),
      .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int k;
      int idx;
      bit lvl;
      bit fin;
   } ev_t;

   ev_t sb[$];
   int  q[$];
   int  total;
   int  bad;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h",
                  tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int t);
      wr_valid = 1'b1;
      wr_time  = TW'(t);
      step();
      wr_valid = 1'b0;
   endtask

   task automatic load(input int tv[$]);
      foreach (tv[i]) wr(tv[i]);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   // Expected toggles for a run, pushed as start is driven.
   task automatic push_run(input int tv[$],
                           input int periods);
      int per;
      bit lvl;
      ev_t e;
      per = tv[tv.size()-1] + 1;
      lvl = 1'b0;
      for (int p = 0; p < periods; p++) begin
         foreach (tv[i]) begin
            lvl   = ~lvl;
            e.k   = p * per + tv[i] + 1;
            e.idx = i;
            e.lvl = lvl;
            e.fin = (i == tv.size() - 1);
            sb.push_back(e);
         end
      end
   endtask

   // Start with wr_sim=1 also drives a same-cycle write of wt.
   task automatic run(input int tv[$],
                      input int periods,
                      input int abort_at,
                      input bit wr_sim,
                      input int wt);
      bit  cur;
      bit  fin;
      bit  pend;
      bit  ended;
      ev_t e;
      cur   = 1'b0;
      pend  = 1'b0;
      ended = 1'b0;
      push_run(tv, periods);
      start = 1'b1;
      if (wr_sim) begin
         wr_valid = 1'b1;
         wr_time  = TW'(wt);
      end
      step();
      start    = 1'b0;
      wr_valid = 1'b0;
      chk("run_busy", busy, 1);
      for (int k = 1; k < 400 && !ended; k++) begin
         step();
         if (pend) begin
            abort = 1'b0;
            chk("abort_busy", busy, 0);
            chk("abort_ctl", ctl, 0);
            chk("abort_done", done, 0);
            sb.delete();
            ended = 1'b1;
         end else begin
            fin = 1'b0;
            if (sb.size() > 0 && sb[0].k == k) begin
               e = sb.pop_front();
               chk("evt_pulse", evt_pulse, 1);
               chk("evt_idx", evt_idx, e.idx);
               cur = e.lvl;
               fin = e.fin;
            end else begin
               chk("evt_quiet", evt_pulse, 0);
            end
            chk("ctl", ctl, cur);
            chk("done", done, fin);
            if (k == abort_at) begin
               abort = 1'b1;
               pend  = 1'b1;
            end else if (sb.size() == 0
                         && abort_at < 0) begin
               step();
               chk("end_done", done, 0);
               chk("end_busy", busy, 0);
               chk("end_ctl", ctl, cur);
               ended = 1'b1;
            end
         end
      end
      if (!ended) chk("run_timeout", 0, 1);
   endtask

   task automatic empty_start();
      start = 1'b1;
      step();
      start = 1'b0;
      chk("empty_done", done, 1);
      chk("empty_busy", busy, 0);
      step();
      chk("empty_done_end", done, 0);
      chk("empty_busy_end", busy, 0);
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      rst_n    = 1'b0;
      wr_valid = 1'b0;
      wr_time  = '0;
      clear    = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      step();
      step();
      chk("rst_ctl", ctl, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_evt", evt_pulse, 0);
      chk("rst_idx", evt_idx, 0);
      chk("rst_err", err, 0);
      chk("rst_ready", wr_ready, 1);
      rst_n = 1'b1;
      step();

      // Basic three-toggle schedule
      q = {3, 5, 10};
      load(q);
      chk("t1_err", err, 0);
      run(q, 1, REP ? 11 : -1, 1'b0, 0);

      // Duplicate time rejected; one entry left
      do_clear();
      wr(5);
      wr(5);
      chk("t2_err", err, 1);
      q = {5};
      run(q, 1, REP ? 6 : -1, 1'b0, 0);
      chk("t2_err_sticky", err, 1);
      do_clear();
      chk("t2_err_clr", err, 0);

      // Fill the table, then an extra offer
      for (int i = 0; i < DEPTH; i++) begin
         chk("t3_ready", wr_ready, 1);
         wr((i + 1) * 10);
      end
      chk("t3_full", wr_ready, 0);
      wr(1000);
      chk("t3_err", err, 0);
      q = {10, 20, 30, 40, 50, 60, 70, 80};
      run(q, 1, REP ? 81 : -1, 1'b0, 0);
      do_clear();
      empty_start();

      // Clear wins over a same-cycle write
      clear    = 1'b1;
      wr_valid = 1'b1;
      wr_time  = 32'd9;
      step();
      clear    = 1'b0;
      wr_valid = 1'b0;
      empty_start();

      // Write with start joins the run
      q = {7};
      run(q, 1, REP ? 8 : -1, 1'b1, 7);
      do_clear();

      // Time 0 and abort, then replay
      q = {0, 4};
      load(q);
      run(q, 1, 2, 1'b0, 0);
      run(q, 1, REP ? 5 : -1, 1'b0, 0);

`ifdef SWITCH_SEQ_REPEAT_EN
      do_clear();
      q = {1, 2};
      load(q);
      run(q, 3, 9, 1'b0, 0);
`endif

      // Asynchronous reset mid-run
      do_clear();
      wr(3);
      wr(2);
      wr(20);
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("t5_pre_ctl", ctl, 1);
      chk("t5_pre_busy", busy, 1);
      chk("t5_pre_err", err, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_ctl", ctl, 0);
      chk("t5_busy", busy, 0);
      chk("t5_done", done, 0);
      chk("t5_evt", evt_pulse, 0);
      chk("t5_idx", evt_idx, 0);
      chk("t5_err", err, 0);
      step();
      rst_n = 1'b1;
      step();
      empty_start();

      $display("test done: total=%0d bad=%0d",
               total, bad);
      $finish;
   end

endmodule
